pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Next-generation main decoder for the 5-stage MIPS pipeline. It decodes opcode and funct in ID and registers the control word into the ID/EX boundary, so outputs have 1-cycle latency. It supports bubble insertion for stall and flush, jumps and links (J/JAL/JR/JALR), memory access width and signedness, and a HALT instruction. HALT is handled by a drain/halt state machine that freezes the PC and reports halted to the debug unit.

Parameters:
NB_OPCODE, 6, opcode width
NB_FUNCT, 6, funct field width
DRAIN_CYCLES, 4, cycles of bubbles after HALT before reporting halted (≥1)
HALT_OPCODE, 6'h3f, opcode of HALT
NB_DRAIN, $clog2(DRAIN_CYCLES+1), drain counter width

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  global enable from debug unit; 0 freezes outputs and FSM
i_valid  in  1  IF/ID holds a real instruction
i_opcode  in  NB_OPCODE  instruction[31:26]
i_funct  in  NB_FUNCT  instruction[5:0]
i_bubble  in  1  load-use stall from hazard unit: emit bubble
i_flush  in  1  control-hazard flush: emit bubble, discard decoded instruction
i_resume  in  1  single-cycle pulse from debug unit: leave HALTED
o_valid  out  1  control word is a real instruction
o_reg_dest  out  2  0=rt, 1=rd, 2=r31
o_alu_op  out  NB_OPCODE  opcode passed to ALU control
o_alu_src  out  1  1=immediate
o_mem_read  out  1  load
o_mem_write  out  1  store
o_mem_width  out  2  0=byte, 1=half, 2=word
o_mem_unsigned  out  1  zero-extend load
o_branch  out  1  BEQ/BNE
o_branch_ne  out  1  BNE
o_jump  out  1  J/JAL
o_jump_reg  out  1  JR/JALR
o_link  out  1  write PC+8 (JAL/JALR)
o_reg_write  out  1  register-file write
o_mem_to_reg  out  1  WB selects memory data
o_halt_pc  out  1  freeze PC/IF-ID
o_halted  out  1  pipeline drained, CPU halted

Behaviour:
- Reset (i_reset=0, async): every output is 0, FSM is in RUN, drain counter is 0.
- Each rising edge with i_enable=1 registers a new control word. With i_enable=0, all outputs, the FSM and the counter hold their values.
- Priority per edge: reset > flush > bubble > FSM bubble > decode.
- Bubble: all control outputs are 0, including o_valid and o_alu_op. i_valid=0 also produces a bubble.
- Decode table:
  - R-type: rd, reg_write. funct 0x08 (JR) gives jump_reg with no reg_write. funct 0x09 (JALR) gives jump_reg, link, reg_write, rd.
  - J (0x02): jump.
  - JAL (0x03): jump, link, reg_write, reg_dest=2.
  - BEQ/BNE: branch; BNE also sets branch_ne.
  - ADDI/SLTI/ANDI/ORI/XORI/LUI: alu_src, reg_write, rt.
  - LB/LH/LW/LBU/LHU/LWU: mem_read, mem_to_reg, reg_write, alu_src, with width and unsigned flag matching the opcode.
  - SB/SH/SW: mem_write, alu_src, width matching the opcode.
- Unknown opcode: bubble (see optional feature).
- FSM states and transitions:
  - RUN: a decoded HALT (i_valid=1, no flush, no bubble) emits a bubble, sets o_halt_pc=1, loads counter with DRAIN_CYCLES-1, and moves to DRAIN.
  - DRAIN: emits bubbles, keeps o_halt_pc=1, and decrements the counter each enabled cycle. At 0 it moves to HALTED and sets o_halted=1 on the same edge. i_flush and i_bubble have no effect.
  - HALTED: emits bubbles with o_halt_pc=1 and o_halted=1. i_resume moves to RUN; o_halt_pc and o_halted clear on that edge.
  - i_resume outside HALTED is ignored.
- Simultaneous events:
  - HALT with i_flush in the same cycle: flush wins, HALT is discarded, FSM stays in RUN.
  - Reset during DRAIN or HALTED: FSM returns to RUN immediately.

Optional Feature:
Macro CTRL_UNIT_ILLEGAL_TRAP_EN.
- Defined: adds output o_illegal (1 bit). An unknown opcode (or unknown R-type funct) with i_valid=1 emits a bubble and sets o_illegal=1 for 1 cycle, then enters DRAIN exactly as HALT does. o_illegal resets to 0.
- Undefined: no port is added; unknown instructions silently become bubbles and the FSM is unaffected.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode and funct constants;
  - reg_dest encodings and mem_width encodings;
  - the FSM state localparams RUN=0, DRAIN=1, HALTED=2;
  - a control-word bundle layout shared with the ID/EX register.
- Sub-module ctrl_decoder: purely combinational opcode/funct → control word plus is_halt/is_illegal flags. The parent owns the registers, priority logic and FSM.

Test Plan:
- LW (0x23) with i_valid=1 → next edge: mem_read=1, mem_to_reg=1, reg_write=1, width=2, unsigned=0, valid=1.
- JAL (0x03), then R-type funct 0x09 → JAL: jump=1, link=1, reg_dest=2; JALR: jump_reg=1, link=1, reg_dest=1.
- ADDI with i_bubble=1 → all outputs 0. ADDI with i_enable=0 → previous word is held.
- HALT with DRAIN_CYCLES=4 → o_halt_pc=1 at edge 1, o_halted=1 at edge 4; resume pulse → both 0 at the next edge.
- HALT with i_flush=1 → bubble, FSM stays in RUN, o_halt_pc=0. Async reset asserted in DRAIN mid-cycle → all outputs 0 immediately.
- With CTRL_UNIT_ILLEGAL_TRAP_EN: opcode 0x3e → o_illegal=1 for 1 cycle, o_halted=1 after 4 cycles. Without the macro → bubble only.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ID-stage main decoder and the ID/EX control register.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
// Contents: opcode/funct constants, reg_dest and mem_width encodings, FSM state
// encodings, the control-word bundle layout and an R-type funct lookup helper.
package cpu_ctrl_pkg;

   // Primary opcodes (instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_LWU   = 6'h27;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // R-type funct codes that need special handling
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   // Register destination select
   localparam logic [1:0] DEST_RT  = 2'd0;
   localparam logic [1:0] DEST_RD  = 2'd1;
   localparam logic [1:0] DEST_R31 = 2'd2;

   // Memory access width
   localparam logic [1:0] WIDTH_BYTE = 2'd0;
   localparam logic [1:0] WIDTH_HALF = 2'd1;
   localparam logic [1:0] WIDTH_WORD = 2'd2;

   // Halt/drain FSM states
   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   // Control word carried across the ID/EX boundary; all-zero is a bubble.
   typedef struct packed {
      logic       valid;
      logic [1:0] reg_dest;
      logic [5:0] alu_op;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_width;
      logic       mem_unsigned;
      logic       branch;
      logic       branch_ne;
      logic       jump;
      logic       jump_reg;
      logic       link;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_word_t;

   // ALU-type R-format functs the ALU control understands (JR/JALR handled apart).
   function automatic logic is_alu_funct(input logic [5:0] funct);
      case (funct)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
         6'h26, 6'h27, 6'h2a, 6'h2b: is_alu_funct = 1'b1;
         default:                    is_alu_funct = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode/funct decoder producing the raw control word.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the parent decides whether the word is registered.
// Ports: i_opcode/i_funct in; o_word (valid=0 for HALT/unknown), o_is_halt, o_is_illegal out.
module ctrl_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter logic [5:0] HALT_OPCODE = 6'h3f
) (
   input  logic [5:0]  i_opcode,
   input  logic [5:0]  i_funct,
   output ctrl_word_t  o_word,
   output logic        o_is_halt,
   output logic        o_is_illegal
);

   always_comb begin
      o_word       = '0;
      o_is_halt    = 1'b0;
      o_is_illegal = 1'b0;
      // HALT is checked first so a configurable HALT opcode cannot alias a real one.
      if (i_opcode == HALT_OPCODE) begin
         o_is_halt = 1'b1;
      end else begin
         case (i_opcode)
            OP_RTYPE: begin
               if (i_funct == FN_JR) begin
                  o_word.valid    = 1'b1;
                  o_word.jump_reg = 1'b1;
               end else if (i_funct == FN_JALR) begin
                  o_word.valid     = 1'b1;
                  o_word.jump_reg  = 1'b1;
                  o_word.link      = 1'b1;
                  o_word.reg_write = 1'b1;
                  o_word.reg_dest  = DEST_RD;
               end else if (is_alu_funct(i_funct)) begin
                  o_word.valid     = 1'b1;
                  o_word.reg_write = 1'b1;
                  o_word.reg_dest  = DEST_RD;
               end else begin
                  o_is_illegal = 1'b1;
               end
            end
            OP_J: begin
               o_word.valid = 1'b1;
               o_word.jump  = 1'b1;
            end
            OP_JAL: begin
               o_word.valid     = 1'b1;
               o_word.jump      = 1'b1;
               o_word.link      = 1'b1;
               o_word.reg_write = 1'b1;
               o_word.reg_dest  = DEST_R31;
            end
            OP_BEQ, OP_BNE: begin
               o_word.valid     = 1'b1;
               o_word.branch    = 1'b1;
               o_word.branch_ne = (i_opcode == OP_BNE);
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
               o_word.valid     = 1'b1;
               o_word.alu_src   = 1'b1;
               o_word.reg_write = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
               o_word.valid        = 1'b1;
               o_word.mem_read     = 1'b1;
               o_word.mem_to_reg   = 1'b1;
               o_word.reg_write    = 1'b1;
               o_word.alu_src      = 1'b1;
               // Opcode bit 2 separates the zero-extending loads.
               o_word.mem_unsigned = i_opcode[2];
               case (i_opcode[1:0])
                  2'b00:   o_word.mem_width = WIDTH_BYTE;
                  2'b01:   o_word.mem_width = WIDTH_HALF;
                  default: o_word.mem_width = WIDTH_WORD;
               endcase
            end
            OP_SB, OP_SH, OP_SW: begin
               o_word.valid     = 1'b1;
               o_word.mem_write = 1'b1;
               o_word.alu_src   = 1'b1;
               case (i_opcode[1:0])
                  2'b00:   o_word.mem_width = WIDTH_BYTE;
                  2'b01:   o_word.mem_width = WIDTH_HALF;
                  default: o_word.mem_width = WIDTH_WORD;
               endcase
            end
            default: o_is_illegal = 1'b1;
         endcase
         if (o_word.valid) o_word.alu_op = i_opcode;
      end
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Main ID-stage decoder with ID/EX control register, bubble/flush priority and HALT drain FSM.
// Latency: 1 cycle from IF/ID contents to registered control word.
// Backpressure: i_enable=0 freezes everything; stall/flush inject bubbles, HALT freezes the PC.
// Ports: i_clock, i_reset (async active-low), i_enable, i_valid, i_opcode, i_funct, i_bubble,
//        i_flush, i_resume in; o_* control word, o_halt_pc, o_halted out.
// Optional: CTRL_UNIT_ILLEGAL_TRAP_EN adds o_illegal and traps unknown instructions into DRAIN.
module pipelined_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int                   NB_OPCODE    = 6,
   parameter int                   NB_FUNCT     = 6,
   parameter int                   DRAIN_CYCLES = 4,
   parameter logic [NB_OPCODE-1:0] HALT_OPCODE  = 6'h3f,
   parameter int                   NB_DRAIN     = $clog2(DRAIN_CYCLES + 1)
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_valid,
   input  logic [NB_OPCODE-1:0] i_opcode,
   input  logic [NB_FUNCT-1:0]  i_funct,
   input  logic                 i_bubble,
   input  logic                 i_flush,
   input  logic                 i_resume,
   output logic                 o_valid,
   output logic [1:0]           o_reg_dest,
   output logic [NB_OPCODE-1:0] o_alu_op,
   output logic                 o_alu_src,
   output logic                 o_mem_read,
   output logic                 o_mem_write,
   output logic [1:0]           o_mem_width,
   output logic                 o_mem_unsigned,
   output logic                 o_branch,
   output logic                 o_branch_ne,
   output logic                 o_jump,
   output logic                 o_jump_reg,
   output logic                 o_link,
   output logic                 o_reg_write,
   output logic                 o_mem_to_reg,
   output logic                 o_halt_pc,
   output logic                 o_halted
`ifdef CTRL_UNIT_ILLEGAL_TRAP_EN
   ,
   output logic                 o_illegal
`endif
);

   ctrl_word_t          dec_word;
   logic                dec_halt, dec_illegal, take_trap;
   ctrl_word_t          word_d, word_q;
   logic [1:0]          state_d, state_q;
   logic [NB_DRAIN-1:0] cnt_d, cnt_q;
   logic                halt_pc_d, halt_pc_q, halted_d, halted_q;
   logic                illegal_d, illegal_q;

   ctrl_decoder #(.HALT_OPCODE(6'(HALT_OPCODE))) u_dec (
      .i_opcode     (6'(i_opcode)),
      .i_funct      (6'(i_funct)),
      .o_word       (dec_word),
      .o_is_halt    (dec_halt),
      .o_is_illegal (dec_illegal)
   );

`ifdef CTRL_UNIT_ILLEGAL_TRAP_EN
   assign take_trap = dec_halt | dec_illegal;
`else
   assign take_trap = dec_halt;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      halt_pc_d = halt_pc_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      if (i_enable) begin
         word_d    = '0;
         illegal_d = 1'b0;
         case (state_q)
            ST_RUN: begin
               halt_pc_d = 1'b0;
               halted_d  = 1'b0;
               // Flush and stall both pre-empt decode, so a flushed HALT never drains.
               if (i_valid && !i_flush && !i_bubble) begin
                  if (take_trap) begin
                     state_d   = ST_DRAIN;
                     cnt_d     = NB_DRAIN'(DRAIN_CYCLES - 1);
                     halt_pc_d = 1'b1;
                     illegal_d = dec_illegal;
                  end else begin
                     word_d = dec_illegal ? '0 : dec_word;
                  end
               end
            end
            ST_DRAIN: begin
               halt_pc_d = 1'b1;
               // Leave when the count reaches zero on this edge, giving DRAIN_CYCLES
               // bubbles in total counting the one emitted for the HALT itself.
               if (cnt_q <= NB_DRAIN'(1)) begin
                  state_d  = ST_HALTED;
                  cnt_d    = '0;
                  halted_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - NB_DRAIN'(1);
               end
            end
            ST_HALTED: begin
               halt_pc_d = !i_resume;
               halted_d  = !i_resume;
               if (i_resume) state_d = ST_RUN;
            end
            default: begin
               state_d   = ST_RUN;
               halt_pc_d = 1'b0;
               halted_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         word_q    <= '0;
         halt_pc_q <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         halt_pc_q <= halt_pc_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   assign o_valid        = word_q.valid;
   assign o_reg_dest     = word_q.reg_dest;
   assign o_alu_op       = NB_OPCODE'(word_q.alu_op);
   assign o_alu_src      = word_q.alu_src;
   assign o_mem_read     = word_q.mem_read;
   assign o_mem_write    = word_q.mem_write;
   assign o_mem_width    = word_q.mem_width;
   assign o_mem_unsigned = word_q.mem_unsigned;
   assign o_branch       = word_q.branch;
   assign o_branch_ne    = word_q.branch_ne;
   assign o_jump         = word_q.jump;
   assign o_jump_reg     = word_q.jump_reg;
   assign o_link         = word_q.link;
   assign o_reg_write    = word_q.reg_write;
   assign o_mem_to_reg   = word_q.mem_to_reg;
   assign o_halt_pc      = halt_pc_q;
   assign o_halted       = halted_q;

`ifdef CTRL_UNIT_ILLEGAL_TRAP_EN
   assign o_illegal = illegal_q;
`else
   // Without the trap the flag never sets; keep it tied off in the register view.
   logic unused_illegal;
   assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
module tb_pipelined_control_unit;

   typedef struct packed {
      logic       valid;
      logic [1:0] reg_dest;
      logic [5:0] alu_op;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_width;
      logic       mem_unsigned;
      logic       branch;
      logic       branch_ne;
      logic       jump;
      logic       jump_reg;
      logic       link;
      logic       reg_write;
      logic       mem_to_reg;
      logic       halt_pc;
      logic       halted;
      logic       illegal;
   } obs_t;

   // Hand-written expected control words
   localparam obs_t Z      = '0;
   localparam obs_t HPC    = '{halt_pc:1'b1, default:'0};
   localparam obs_t HLT    = '{halt_pc:1'b1, halted:1'b1, default:'0};
   localparam obs_t ILL    = '{halt_pc:1'b1, illegal:1'b1, default:'0};
   localparam obs_t W_LW   = '{valid:1'b1, alu_op:6'h23, alu_src:1'b1, mem_read:1'b1, mem_width:2'd2, reg_write:1'b1, mem_to_reg:1'b1, default:'0};
   localparam obs_t W_LBU  = '{valid:1'b1, alu_op:6'h24, alu_src:1'b1, mem_read:1'b1, mem_width:2'd0, mem_unsigned:1'b1, reg_write:1'b1, mem_to_reg:1'b1, default:'0};
   localparam obs_t W_LH   = '{valid:1'b1, alu_op:6'h21, alu_src:1'b1, mem_read:1'b1, mem_width:2'd1, reg_write:1'b1, mem_to_reg:1'b1, default:'0};
   localparam obs_t W_SB   = '{valid:1'b1, alu_op:6'h28, alu_src:1'b1, mem_write:1'b1, mem_width:2'd0, default:'0};
   localparam obs_t W_SW   = '{valid:1'b1, alu_op:6'h2b, alu_src:1'b1, mem_write:1'b1, mem_width:2'd2, default:'0};
   localparam obs_t W_JAL  = '{valid:1'b1, alu_op:6'h03, reg_dest:2'd2, jump:1'b1, link:1'b1, reg_write:1'b1, default:'0};
   localparam obs_t W_JALR = '{valid:1'b1, reg_dest:2'd1, jump_reg:1'b1, link:1'b1, reg_write:1'b1, default:'0};
   localparam obs_t W_JR   = '{valid:1'b1, jump_reg:1'b1, default:'0};
   localparam obs_t W_ADDU = '{valid:1'b1, reg_dest:2'd1, reg_write:1'b1, default:'0};
   localparam obs_t W_BNE  = '{valid:1'b1, alu_op:6'h05, branch:1'b1, branch_ne:1'b1, default:'0};
   localparam obs_t W_BEQ  = '{valid:1'b1, alu_op:6'h04, branch:1'b1, default:'0};
   localparam obs_t W_J    = '{valid:1'b1, alu_op:6'h02, jump:1'b1, default:'0};
   localparam obs_t W_ADDI = '{valid:1'b1, alu_op:6'h08, alu_src:1'b1, reg_write:1'b1, default:'0};
   localparam obs_t W_ORI  = '{valid:1'b1, alu_op:6'h0d, alu_src:1'b1, reg_write:1'b1, default:'0};
   localparam obs_t W_LUI  = '{valid:1'b1, alu_op:6'h0f, alu_src:1'b1, reg_write:1'b1, default:'0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_enable = 1'b1, i_valid = 1'b0, i_bubble = 1'b0, i_flush = 1'b0, i_resume = 1'b0;
   logic [5:0] i_opcode = '0, i_funct = '0;
   logic       o_valid, o_alu_src, o_mem_read, o_mem_write, o_mem_unsigned, o_branch, o_branch_ne;
   logic       o_jump, o_jump_reg, o_link, o_reg_write, o_mem_to_reg, o_halt_pc, o_halted;
   logic [1:0] o_reg_dest, o_mem_width;
   logic [5:0] o_alu_op;
   logic       ill_bit;
   obs_t       act;

   always #5 clk = ~clk;

   pipelined_control_unit dut (
      .i_clock(clk), .i_reset(rst_n), .i_enable(i_enable), .i_valid(i_valid),
      .i_opcode(i_opcode), .i_funct(i_funct), .i_bubble(i_bubble), .i_flush(i_flush),
      .i_resume(i_resume), .o_valid(o_valid), .o_reg_dest(o_reg_dest), .o_alu_op(o_alu_op),
      .o_alu_src(o_alu_src), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
      .o_mem_width(o_mem_width), .o_mem_unsigned(o_mem_unsigned), .o_branch(o_branch),
      .o_branch_ne(o_branch_ne), .o_jump(o_jump), .o_jump_reg(o_jump_reg), .o_link(o_link),
      .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg), .o_halt_pc(o_halt_pc),
      .o_halted(o_halted)
`ifdef CTRL_UNIT_ILLEGAL_TRAP_EN
      , .o_illegal(ill_bit)
`endif
   );

`ifndef CTRL_UNIT_ILLEGAL_TRAP_EN
   assign ill_bit = 1'b0;
`endif

   assign act = {o_valid, o_reg_dest, o_alu_op, o_alu_src, o_mem_read, o_mem_write, o_mem_width,
                 o_mem_unsigned, o_branch, o_branch_ne, o_jump, o_jump_reg, o_link, o_reg_write,
                 o_mem_to_reg, o_halt_pc, o_halted, ill_bit};

   obs_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass = 0;

   task automatic check(input string nm, input obs_t got, input obs_t want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, want);
   endtask

   // Drive one cycle's inputs and queue the word expected after the following edge.
   task automatic step(input string nm, input logic en, input logic v, input logic [5:0] op,
                       input logic [5:0] fn, input logic bub, input logic fl, input logic res,
                       input obs_t want);
      @(negedge clk);
      i_enable = en; i_valid = v; i_opcode = op; i_funct = fn;
      i_bubble = bub; i_flush = fl; i_resume = res;
      exp_q.push_back(want);
      name_q.push_back(nm);
   endtask

   // Monitor: compare each registered word just after the edge that produced it.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin : pop
            obs_t  w;
            string n;
            w = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, act, w);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      #2;
      check("reset_state", act, Z);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

      //    name          en    v     op     fn     bub   fl    res   expected
      step("lw",         1'b1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, W_LW);
      step("lbu",        1'b1, 1'b1, 6'h24, 6'h00, 1'b0, 1'b0, 1'b0, W_LBU);
      step("lh",         1'b1, 1'b1, 6'h21, 6'h00, 1'b0, 1'b0, 1'b0, W_LH);
      step("sb",         1'b1, 1'b1, 6'h28, 6'h00, 1'b0, 1'b0, 1'b0, W_SB);
      step("sw",         1'b1, 1'b1, 6'h2b, 6'h00, 1'b0, 1'b0, 1'b0, W_SW);
      step("jal",        1'b1, 1'b1, 6'h03, 6'h00, 1'b0, 1'b0, 1'b0, W_JAL);
      step("jalr",       1'b1, 1'b1, 6'h00, 6'h09, 1'b0, 1'b0, 1'b0, W_JALR);
      step("jr",         1'b1, 1'b1, 6'h00, 6'h08, 1'b0, 1'b0, 1'b0, W_JR);
      step("addu",       1'b1, 1'b1, 6'h00, 6'h21, 1'b0, 1'b0, 1'b0, W_ADDU);
      step("bne",        1'b1, 1'b1, 6'h05, 6'h00, 1'b0, 1'b0, 1'b0, W_BNE);
      step("beq",        1'b1, 1'b1, 6'h04, 6'h00, 1'b0, 1'b0, 1'b0, W_BEQ);
      step("j",          1'b1, 1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b0, W_J);
      step("addi_bub",   1'b1, 1'b1, 6'h08, 6'h00, 1'b1, 1'b0, 1'b0, Z);
      step("addi",       1'b1, 1'b1, 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, W_ADDI);
      step("ori_hold",   1'b0, 1'b1, 6'h0d, 6'h00, 1'b0, 1'b0, 1'b0, W_ADDI);
      step("ori",        1'b1, 1'b1, 6'h0d, 6'h00, 1'b0, 1'b0, 1'b0, W_ORI);
      step("not_valid",  1'b1, 1'b0, 6'h0d, 6'h00, 1'b0, 1'b0, 1'b0, Z);
      step("halt_flush", 1'b1, 1'b1, 6'h3f, 6'h00, 1'b0, 1'b1, 1'b0, Z);
      step("lui_run",    1'b1, 1'b1, 6'h0f, 6'h00, 1'b0, 1'b0, 1'b0, W_LUI);
      // HALT: halt_pc on edge 1, halted on edge 4; flush/resume ignored while draining
      step("halt_e1",    1'b1, 1'b1, 6'h3f, 6'h00, 1'b0, 1'b0, 1'b0, HPC);
      step("drain_fl",   1'b1, 1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, HPC);
      step("drain_res",  1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, HPC);
      step("halted_e4",  1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, HLT);
      step("halted_hold",1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, HLT);
      step("halted_stay",1'b1, 1'b1, 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, HLT);
      step("resume",     1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, Z);
      step("addi_run",   1'b1, 1'b1, 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, W_ADDI);
`ifdef CTRL_UNIT_ILLEGAL_TRAP_EN
      step("ill_trap",   1'b1, 1'b1, 6'h3e, 6'h00, 1'b0, 1'b0, 1'b0, ILL);
      step("ill_e2",     1'b1, 1'b1, 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, HPC);
      step("ill_e3",     1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, HPC);
      step("ill_e4",     1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, HLT);
      step("ill_resume", 1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, Z);
`else
      step("ill_bubble", 1'b1, 1'b1, 6'h3e, 6'h00, 1'b0, 1'b0, 1'b0, Z);
      step("ill_after",  1'b1, 1'b1, 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, W_ADDI);
      step("bad_funct",  1'b1, 1'b1, 6'h00, 6'h3f, 1'b0, 1'b0, 1'b0, Z);
`endif
      // Async reset asserted mid-cycle while draining
      step("halt_again", 1'b1, 1'b1, 6'h3f, 6'h00, 1'b0, 1'b0, 1'b0, HPC);
      step("drain_idle", 1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, HPC);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", act, Z);
      @(negedge clk);
      rst_n = 1'b1;
      step("post_reset", 1'b1, 1'b1, 6'h08, 6'h00, 1'b0, 1'b0, 1'b0, W_ADDI);
      step("tail_idle",  1'b1, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, Z);

      @(posedge clk);
      #3;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain_queue: %0d expectations left, required 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
